// File: rtl/serial_arith_pkg.sv
// Shared types and sizing helpers for the bit-serial arithmetic cells.
package serial_arith_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    // Bit-counter width for a WIDTH-bit operation; never narrower than 1 bit.
    function automatic int unsigned cnt_width(input int unsigned w);
        return (w <= 1) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/full_subtractor_cell.sv
// One-bit full subtractor composed of two cascaded half-subtractor stages.
module full_subtractor_cell (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic diff,
    output logic bout
);

    logic hs1_diff;
    logic hs1_bout;
    logic hs2_bout;

    assign hs1_diff = a ^ b;
    assign hs1_bout = ~a & b;

    assign diff     = hs1_diff ^ bin;
    assign hs2_bout = ~hs1_diff & bin;

    assign bout     = hs1_bout | hs2_bout;

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: diff = a - b mod 2^WIDTH, one bit per clock, LSB first.
module serial_subtractor
    import serial_arith_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow
);

    localparam int unsigned   CW   = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_e           state_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] res_q;
    logic [WIDTH-1:0] res_d;
    logic             brw_q;
    logic [CW-1:0]    cnt_q;
    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] diff_q;
    logic             borrow_q;

    logic             cell_diff;
    logic             cell_bout;

    full_subtractor_cell u_cell (
        .a    (a_q[0]),
        .b    (b_q[0]),
        .bin  (brw_q),
        .diff (cell_diff),
        .bout (cell_bout)
    );

    // New result bit enters from the MSB side; written per-bit so WIDTH = 1 needs no slice.
    always_comb begin
        res_d            = res_q >> 1;
        res_d[WIDTH-1]   = cell_diff;
    end

    // DONE accepts start like IDLE so a held start yields one operation every WIDTH+1 cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            res_q    <= '0;
            brw_q    <= 1'b0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        a_q     <= a;
                        b_q     <= b;
                        brw_q   <= 1'b0;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= SHIFT;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                SHIFT: begin
                    a_q   <= a_q >> 1;
                    b_q   <= b_q >> 1;
                    res_q <= res_d;
                    brw_q <= cell_bout;
                    cnt_q <= cnt_q + CW'(1);
                    if (cnt_q == LAST) begin
                        diff_q   <= res_d;
                        borrow_q <= cell_bout;
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
                        cnt_q    <= '0;
                        state_q  <= DONE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign diff   = diff_q;
    assign borrow = borrow_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor at WIDTH = 8 and WIDTH = 1.
module tb_serial_subtractor;

    typedef struct {
        logic [7:0] d;
        logic       br;
        int         cyc;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start8 = 1'b0;
    logic [7:0] a8 = '0;
    logic [7:0] b8 = '0;
    logic       busy8;
    logic       done8;
    logic [7:0] diff8;
    logic       borrow8;
    logic       start1 = 1'b0;
    logic       a1 = 1'b0;
    logic       b1 = 1'b0;
    logic       busy1;
    logic       done1;
    logic       diff1;
    logic       borrow1;

    exp_t q8[$];
    exp_t q1[$];
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    int   done8_cnt = 0;
    int   run8 = 0;
    int   run1 = 0;
    logic prev8 = 1'b0;
    logic prev1 = 1'b0;
    logic [7:0] hold8_d = '0;
    logic       hold8_b = 1'b0;

    serial_subtractor #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .diff(diff8), .borrow(borrow8)
    );

    serial_subtractor #(.WIDTH(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1),
        .busy(busy1), .done(done1), .diff(diff1), .borrow(borrow1)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin : mon8
        exp_t e;
        if (rst) begin
            prev8   = 1'b0;
            run8    = 0;
            hold8_d = '0;
            hold8_b = 1'b0;
        end else begin
            if (busy8)
                chk("diff8_hold", {diff8, borrow8}, {hold8_d, hold8_b});
            if (done8) begin
                done8_cnt++;
                if (q8.size() == 0) begin
                    chk("done8_unexpected", done8, 0);
                end else begin
                    e = q8.pop_front();
                    chk("diff8", diff8, e.d);
                    chk("borrow8", borrow8, e.br);
                    chk("latency8", cyc, e.cyc);
                    hold8_d = e.d;
                    hold8_b = e.br;
                end
            end
            if (busy8) run8++;
            else if (prev8) begin
                chk("busy8_len", run8, 8);
                run8 = 0;
            end
            prev8 = busy8;
        end
    end

    always @(negedge clk) begin : mon1
        exp_t e;
        if (rst) begin
            prev1 = 1'b0;
            run1  = 0;
        end else begin
            if (done1) begin
                if (q1.size() == 0) begin
                    chk("done1_unexpected", done1, 0);
                end else begin
                    e = q1.pop_front();
                    chk("diff1", {7'b0, diff1}, e.d);
                    chk("borrow1", borrow1, e.br);
                    chk("latency1", cyc, e.cyc);
                end
            end
            if (busy1) run1++;
            else if (prev1) begin
                chk("busy1_len", run1, 1);
                run1 = 0;
            end
            prev1 = busy1;
        end
    end

    task automatic drain();
        for (int i = 0; i < 40 && (q8.size() != 0 || q1.size() != 0); i++)
            @(posedge clk);
        if (q8.size() != 0 || q1.size() != 0)
            chk("drain_timeout", q8.size() + q1.size(), 0);
        @(posedge clk);
    endtask

    task automatic op8(input logic [7:0] x, input logic [7:0] y);
        exp_t e;
        @(posedge clk); #1;
        a8 = x; b8 = y; start8 = 1'b1;
        e.d = x - y; e.br = (x < y); e.cyc = cyc + 1 + 8;
        q8.push_back(e);
        @(posedge clk); #1;
        start8 = 1'b0;
        drain();
    endtask

    task automatic op1(input logic x, input logic y);
        exp_t e;
        @(posedge clk); #1;
        a1 = x; b1 = y; start1 = 1'b1;
        e.d = 8'((int'(x) - int'(y)) & 1); e.br = (x < y); e.cyc = cyc + 1 + 1;
        q1.push_back(e);
        @(posedge clk); #1;
        start1 = 1'b0;
        drain();
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        exp_t e;
        int   base;
        int   dstart;
        int   low_cnt;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_diff8", diff8, 0);
        chk("rst_borrow8", borrow8, 0);
        chk("rst_busy8", busy8, 0);
        chk("rst_done8", done8, 0);
        chk("rst_diff1", diff1, 0);
        chk("rst_busy1", busy1, 0);
        rst = 1'b0;

        op8(8'h5A, 8'h3C);
        op8(8'h00, 8'h01);
        op8(8'h80, 8'h80);
        op8(8'hFF, 8'hFF);
        op8(8'h00, 8'hFF);
        for (int i = 0; i < 20; i++)
            op8(8'($urandom), 8'($urandom));

        // Second start pulses during SHIFT must be ignored.
        @(posedge clk); #1;
        a8 = 8'h10; b8 = 8'h01; start8 = 1'b1;
        e.d = 8'h0F; e.br = 1'b0; e.cyc = cyc + 1 + 8;
        q8.push_back(e);
        dstart = done8_cnt;
        @(posedge clk); #1;
        start8 = 1'b0; a8 = 8'hFF; b8 = 8'h00;
        repeat (2) @(posedge clk); #1;
        start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        repeat (4) @(posedge clk); #1;
        start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        repeat (12) @(posedge clk);
        chk("ignored_start_dones", done8_cnt - dstart, 1);
        drain();

        // Start held high for 30 edges: accepts every 9 cycles.
        @(posedge clk); #1;
        a8 = 8'h03; b8 = 8'h05; start8 = 1'b1;
        base = cyc + 1;
        for (int k = 0; k < 4; k++) begin
            e.d = 8'hFE; e.br = 1'b1; e.cyc = base + k * 9 + 8;
            q8.push_back(e);
        end
        @(posedge clk);
        low_cnt = 0;
        for (int k = 0; k < 27; k++) begin
            @(negedge clk);
            if (!busy8) low_cnt++;
        end
        chk("held_busy_low_cycles", low_cnt, 3);
        repeat (3) @(posedge clk); #1;
        start8 = 1'b0;
        drain();

        // Reset in the middle of an operation.
        @(posedge clk); #1;
        a8 = 8'h20; b8 = 8'h01; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        repeat (4) @(posedge clk); #1;
        rst = 1'b1;
        #1;
        chk("midrst_diff8", diff8, 0);
        chk("midrst_borrow8", borrow8, 0);
        chk("midrst_busy8", busy8, 0);
        chk("midrst_done8", done8, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        dstart = done8_cnt;
        repeat (12) @(posedge clk);
        chk("midrst_no_done", done8_cnt - dstart, 0);
        op8(8'h07, 8'h02);

        op1(1'b0, 1'b0);
        op1(1'b0, 1'b1);
        op1(1'b1, 1'b0);
        op1(1'b1, 1'b1);
        for (int i = 0; i < 8; i++)
            op1(1'($urandom), 1'($urandom));

        repeat (3) @(posedge clk);
        chk("queues_empty", q8.size() + q1.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
